// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its bus monitor:
// light codes, default phase times, phase indices and the phase successor.
package traffic_light_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam int RED_TIME_DEF    = 10;
  localparam int GREEN_TIME_DEF  = 10;
  localparam int YELLOW_TIME_DEF = 5;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic enc;
    logic seq;
    logic dur;
  } err_vec_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_RED:    nxt = PH_GREEN;
      PH_GREEN:  nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      default:   nxt = PH_NONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/traffic_light_decoder.sv
// Combinational decode of the one-hot light code into a validity flag and
// a phase index; anything other than a single legal code decodes to NONE.
module traffic_light_decoder
  import traffic_light_pkg::*;
(
  input  logic [2:0] light_i,
  output logic       valid_o,
  output logic [1:0] phase_o
);

  always_comb begin
    valid_o = 1'b1;
    phase_o = PH_NONE;
    case (light_i)
      LIGHT_RED:    phase_o = PH_RED;
      LIGHT_GREEN:  phase_o = PH_GREEN;
      LIGHT_YELLOW: phase_o = PH_YELLOW;
      default:      valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's light bus: locks onto the phase
// sequence, measures dwell and reports encoding/sequence/duration errors.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_TIME    = RED_TIME_DEF,
  parameter int GREEN_TIME  = GREEN_TIME_DEF,
  parameter int YELLOW_TIME = YELLOW_TIME_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       light,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] dwell,
  output logic             enc_err,
  output logic             seq_err,
  output logic             dur_err,
  output logic [2:0]       err_sticky,
  output logic [15:0]      round_count
);

  mon_state_e       state_q, state_d;
  logic [2:0]       prev_light_q;
  logic [1:0]       phase_q, phase_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             over_q, over_d;
  err_vec_t         pulse_q, pulse_d;
  err_vec_t         sticky_q, sticky_d;
  logic [15:0]      round_q, round_d;

  logic             cur_valid;
  logic [1:0]       cur_phase;
  logic             prev_valid;
  logic             change;
  logic             round_inc;
  logic [CNT_W-1:0] dwell_inc;

  traffic_light_decoder u_decoder (
    .light_i (light),
    .valid_o (cur_valid),
    .phase_o (cur_phase)
  );

  // Expected number of sampled cycles for a phase (controller load + 1).
  function automatic logic [CNT_W-1:0] expected_dwell(input logic [1:0] ph);
    logic [CNT_W-1:0] len;
    case (ph)
      PH_RED:    len = CNT_W'(RED_TIME + 1);
      PH_GREEN:  len = CNT_W'(GREEN_TIME + 1);
      PH_YELLOW: len = CNT_W'(YELLOW_TIME + 1);
      default:   len = '0;
    endcase
    return len;
  endfunction

  // phase_q always holds the decode of the previously sampled light.
  assign prev_valid = (phase_q != PH_NONE);
  assign change     = cur_valid && prev_valid && (light != prev_light_q);
  assign dwell_inc  = (dwell_q == {CNT_W{1'b1}}) ? dwell_q : dwell_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (change)     state_d = ST_TRACK;
      ST_TRACK: if (!cur_valid) state_d = ST_SYNC;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    phase_d   = cur_phase;
    locked_d  = (state_d == ST_TRACK);
    dwell_d   = '0;
    over_d    = 1'b0;
    pulse_d   = '0;
    round_inc = 1'b0;

    pulse_d.enc = !cur_valid;

    case (state_q)
      ST_SYNC: begin
        // The first change after (re)sync is only a lock point: the
        // controller's first phase after its own reset is short.
        if (change) dwell_d = CNT_W'(1);
      end
      ST_TRACK: begin
        if (cur_valid && !change) begin
          dwell_d = dwell_inc;
          over_d  = over_q;
          if (!over_q && (dwell_inc == expected_dwell(phase_q) + CNT_W'(1))) begin
            pulse_d.dur = 1'b1;
            over_d      = 1'b1;
          end
        end else if (change) begin
          dwell_d     = CNT_W'(1);
          pulse_d.seq = (cur_phase != next_phase(phase_q));
          pulse_d.dur = !over_q && (dwell_q != expected_dwell(phase_q));
          round_inc   = (phase_q == PH_YELLOW) && (cur_phase == PH_RED);
        end
      end
      default: ;
    endcase

    // Errors and increments raised in a clear cycle survive the clear.
    sticky_d = (clear ? err_vec_t'(3'b000) : sticky_q) | pulse_d;
    round_d  = (clear ? 16'd0 : round_q) + {15'd0, round_inc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_light_q <= 3'b000;
      phase_q      <= PH_NONE;
      locked_q     <= 1'b0;
      dwell_q      <= '0;
      over_q       <= 1'b0;
      pulse_q      <= '0;
      sticky_q     <= '0;
      round_q      <= '0;
    end else begin
      prev_light_q <= light;
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      dwell_q      <= dwell_d;
      over_q       <= over_d;
      pulse_q      <= pulse_d;
      sticky_q     <= sticky_d;
      round_q      <= round_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign dwell       = dwell_q;
  assign enc_err     = pulse_q.enc;
  assign seq_err     = pulse_q.seq;
  assign dur_err     = pulse_q.dur;
  assign err_sticky  = sticky_q;
  assign round_count = round_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: scenario tasks drive the light bus and
// push expected outputs; a posedge monitor pops and compares them.
module tb_traffic_light_monitor;

  localparam int RT = 10;
  localparam int GT = 10;
  localparam int YT = 5;
  localparam int CW = 8;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] BAD = 3'b110;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    light = R;
  logic          clear = 1'b0;
  logic [1:0]    phase;
  logic          locked;
  logic [CW-1:0] dwell;
  logic          enc_err, seq_err, dur_err;
  logic [2:0]    err_sticky;
  logic [15:0]   round_count;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .RED_TIME    (RT),
    .GREEN_TIME  (GT),
    .YELLOW_TIME (YT),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .light       (light),
    .clear       (clear),
    .phase       (phase),
    .locked      (locked),
    .dwell       (dwell),
    .enc_err     (enc_err),
    .seq_err     (seq_err),
    .dur_err     (dur_err),
    .err_sticky  (err_sticky),
    .round_count (round_count)
  );

  typedef struct packed {
    logic [1:0]    phase;
    logic          locked;
    logic [CW-1:0] dwell;
    logic [2:0]    pulse;
    logic [2:0]    sticky;
    logic [15:0]   rounds;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_g;

  int errors = 0;
  int checks = 0;
  int n_enc = 0;
  int n_seq = 0;
  int n_dur = 0;

  // Reference model state
  bit          m_lock;
  bit          m_over;
  logic [2:0]  m_prev;
  int          m_phase;
  int          m_dwell;
  logic [2:0]  m_sticky;
  logic [15:0] m_rounds;

  function automatic int dec(input logic [2:0] l);
    if (l == R) return 1;
    if (l == G) return 2;
    if (l == Y) return 3;
    return 0;
  endfunction

  function automatic int exp_len(input int p);
    if (p == 1) return RT + 1;
    if (p == 2) return GT + 1;
    if (p == 3) return YT + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_over = 0; m_prev = 3'b000; m_phase = 0; m_dwell = 0;
    m_sticky = 3'b000; m_rounds = 16'd0;
  endtask

  task automatic step(input logic [2:0] l, input logic c);
    exp_t e;
    int p, pp;
    logic enc, seq, dur, inc;
    light = l;
    clear = c;
    enc = 0; seq = 0; dur = 0; inc = 0;
    if (!reset_n) begin
      model_reset();
    end else begin
      p  = dec(l);
      pp = dec(m_prev);
      enc = (p == 0);
      if (!m_lock) begin
        m_dwell = 0;
        if (p != 0 && pp != 0 && p != pp) begin
          m_lock = 1; m_dwell = 1; m_over = 0;
        end
      end else if (p == 0) begin
        m_lock = 0; m_dwell = 0; m_over = 0;
      end else if (p == pp) begin
        if (m_dwell < (1 << CW) - 1) m_dwell++;
        if (!m_over && m_dwell == exp_len(pp) + 1) begin
          dur = 1; m_over = 1;
        end
      end else begin
        seq = (p != (pp % 3) + 1);
        dur = !m_over && (m_dwell != exp_len(pp));
        inc = (pp == 3) && (p == 1);
        m_dwell = 1; m_over = 0;
      end
      if (c) begin
        m_sticky = 3'b000; m_rounds = 16'd0;
      end
      m_sticky = m_sticky | {enc, seq, dur};
      m_rounds = m_rounds + {15'd0, inc};
      m_prev  = l;
      m_phase = p;
    end
    e.phase  = 2'(m_phase);
    e.locked = m_lock;
    e.dwell  = CW'(m_dwell);
    e.pulse  = {enc, seq, dur};
    e.sticky = m_sticky;
    e.rounds = m_rounds;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [2:0] l, input int n);
    repeat (n) step(l, 1'b0);
  endtask

  // Scoreboard consumer: one comparison per driven cycle.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_g = {phase, locked, dwell, enc_err, seq_err, dur_err, err_sticky, round_count};
      n_enc += int'(enc_err);
      n_seq += int'(seq_err);
      n_dur += int'(dur_err);
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL cycle_out t=%0t: got ph=%0d lk=%0b dw=%0d pul=%b st=%b rc=%0d, want ph=%0d lk=%0b dw=%0d pul=%b st=%b rc=%0d",
                 $time, mon_g.phase, mon_g.locked, mon_g.dwell, mon_g.pulse, mon_g.sticky, mon_g.rounds,
                 mon_e.phase, mon_e.locked, mon_e.dwell, mon_e.pulse, mon_e.sticky, mon_e.rounds);
      end
    end
  end

  task automatic clr_stats();
    n_enc = 0; n_seq = 0; n_dur = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({phase, locked, dwell, enc_err, seq_err, dur_err, err_sticky, round_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h, want 0",
               {phase, locked, dwell, enc_err, seq_err, dur_err, err_sticky, round_count});
    end
    @(posedge clk); #2;
    step(R, 1'b0);
    step(R, 1'b0);
  endtask

  task automatic test_golden();
    reset_n = 1'b1;
    clr_stats();
    step(R, 1'b0);
    step(G, 1'b0);
    checks++;
    if (locked !== 1'b1 || dwell !== 8'd1) begin
      errors++;
      $display("FAIL golden_lock: got locked=%0b dwell=%0d, want 1/1", locked, dwell);
    end
    run(G, 10);
    for (int r = 0; r < 3; r++) begin
      if (r > 0) run(G, 11);
      checks++;
      if (dwell !== 8'd11) begin
        errors++; $display("FAIL golden_green_peak: got %0d want 11", dwell);
      end
      run(Y, 6);
      checks++;
      if (dwell !== 8'd6) begin
        errors++; $display("FAIL golden_yellow_peak: got %0d want 6", dwell);
      end
      run(R, 11);
      checks++;
      if (dwell !== 8'd11) begin
        errors++; $display("FAIL golden_red_peak: got %0d want 11", dwell);
      end
    end
    checks++;
    if (round_count !== 16'd3) begin
      errors++; $display("FAIL golden_rounds: got %0d want 3", round_count);
    end
    checks++;
    if (n_enc + n_seq + n_dur != 0 || err_sticky !== 3'b000) begin
      errors++;
      $display("FAIL golden_clean: got pulses=%0d sticky=%b, want 0/000", n_enc + n_seq + n_dur, err_sticky);
    end
  endtask

  task automatic test_short_green();
    clr_stats();
    run(G, 8);
    step(Y, 1'b0);
    checks++;
    if (n_dur != 1 || n_seq != 0 || dur_err !== 1'b1 || err_sticky !== 3'b001) begin
      errors++;
      $display("FAIL short_green: got dur=%0d seq=%0d sticky=%b, want 1/0/001", n_dur, n_seq, err_sticky);
    end
    run(Y, 5);
  endtask

  task automatic test_overstay();
    clr_stats();
    step(R, 1'b1);
    checks++;
    if (round_count !== 16'd1 || err_sticky !== 3'b000) begin
      errors++;
      $display("FAIL clear_with_inc: got rc=%0d sticky=%b, want 1/000", round_count, err_sticky);
    end
    run(R, 10);
    checks++;
    if (n_dur != 0) begin
      errors++; $display("FAIL overstay_early: got dur=%0d want 0", n_dur);
    end
    step(R, 1'b0);
    checks++;
    if (dur_err !== 1'b1 || dwell !== 8'd12) begin
      errors++; $display("FAIL overstay_flag: got dur=%0b dwell=%0d, want 1/12", dur_err, dwell);
    end
    run(R, 3);
    step(G, 1'b0);
    checks++;
    if (n_dur != 1 || err_sticky !== 3'b001) begin
      errors++; $display("FAIL overstay_once: got dur=%0d sticky=%b, want 1/001", n_dur, err_sticky);
    end
    run(G, 10);
  endtask

  task automatic test_skip_yellow();
    clr_stats();
    step(R, 1'b0);
    checks++;
    if (seq_err !== 1'b1 || dur_err !== 1'b0 || round_count !== 16'd1) begin
      errors++;
      $display("FAIL skip_yellow: got seq=%0b dur=%0b rc=%0d, want 1/0/1", seq_err, dur_err, round_count);
    end
    run(R, 10);
    step(G, 1'b0);
    checks++;
    if (n_seq != 1 || n_dur != 0 || locked !== 1'b1 || err_sticky !== 3'b011) begin
      errors++;
      $display("FAIL skip_recover: got seq=%0d dur=%0d lk=%0b st=%b, want 1/0/1/011", n_seq, n_dur, locked, err_sticky);
    end
  endtask

  task automatic test_illegal();
    clr_stats();
    run(G, 4);
    step(BAD, 1'b0);
    checks++;
    if (enc_err !== 1'b1 || locked !== 1'b0 || phase !== 2'd0 || dwell !== 8'd0) begin
      errors++;
      $display("FAIL illegal_code: got enc=%0b lk=%0b ph=%0d dw=%0d, want 1/0/0/0", enc_err, locked, phase, dwell);
    end
    run(G, 3);
    step(Y, 1'b0);
    checks++;
    if (locked !== 1'b1 || dwell !== 8'd1 || n_enc != 1 || n_seq != 0 || n_dur != 0) begin
      errors++;
      $display("FAIL relock: got lk=%0b dw=%0d enc=%0d seq=%0d dur=%0d, want 1/1/1/0/0", locked, dwell, n_enc, n_seq, n_dur);
    end
    run(Y, 5);
    run(R, 11);
  endtask

  task automatic test_clear_dur();
    run(G, 5);
    step(Y, 1'b1);
    checks++;
    if (dur_err !== 1'b1 || err_sticky !== 3'b001 || round_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_with_dur: got dur=%0b st=%b rc=%0d, want 1/001/0", dur_err, err_sticky, round_count);
    end
  endtask

  task automatic test_reset_mid();
    run(Y, 2);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({phase, locked, dwell, enc_err, seq_err, dur_err, err_sticky, round_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h, want 0",
               {phase, locked, dwell, enc_err, seq_err, dur_err, err_sticky, round_count});
    end
    @(posedge clk); #2;
    run(Y, 2);
    reset_n = 1'b1;
    clr_stats();
    run(Y, 2);
    step(R, 1'b0);
    checks++;
    if (locked !== 1'b1 || dwell !== 8'd1 || round_count !== 16'd0 || n_enc + n_seq + n_dur != 0) begin
      errors++;
      $display("FAIL reset_relock: got lk=%0b dw=%0d rc=%0d pulses=%0d, want 1/1/0/0",
               locked, dwell, round_count, n_enc + n_seq + n_dur);
    end
    run(R, 3);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_short_green();
    test_overstay();
    test_skip_yellow();
    test_illegal();
    test_clear_dur();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
